// File: rtl/ifu_ibuf.sv
`default_nettype none
// ============================================================================
// Module   : ifu_ibuf
// Brief    : Instruction buffer between fetch and decode. In-order FIFO of
//            (PC, instruction) pairs with flush for branch/exception redirect.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_ibuf #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_pc,
    input  logic [DW-1:0]            in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [AW-1:0]            out_pc,
    output logic [DW-1:0]            out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_EMPTY = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_1 = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_1 = c_PTR_W'(1);

    logic [AW-1:0]      r_mem_pc    [DEPTH];
    logic [DW-1:0]      r_mem_instr [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Handshake qualifiers; ready/valid depend only on the registered count,
    // so a full buffer refuses input even when decode pops in the same cycle.
    always_comb begin
        in_ready  = (r_count != c_FULL);
        out_valid = (r_count != c_EMPTY);
        w_push    = in_valid && in_ready;
        w_pop     = out_valid && out_ready;
        out_pc    = r_mem_pc[r_rptr];
        out_instr = r_mem_instr[r_rptr];
        count     = r_count;
    end

    // Entry storage: cleared by reset, written only on an accepted push.
    // Flush leaves contents alone; the pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= '0;
            end
        end else if (w_push && !flush) begin
            r_mem_pc[r_wptr]    <= in_pc;
            r_mem_instr[r_wptr] <= in_instr;
        end
    end

    // Pointer and occupancy control; reset beats flush, flush beats push/pop.
    // DEPTH is a power of two, so pointer wrap is natural binary overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_ibuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_ibuf
// Brief    : Directed self-checking bench for ifu_ibuf (DEPTH=4, DW=AW=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_ibuf;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int checks;
    int failures;

    ifu_ibuf #(.DEPTH(4), .DW(32), .AW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word derived from the PC so order errors show in both fields.
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h5555_0000;
    endfunction

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_one(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr_of(pc);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%0h exp=0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%0h exp=0", out_instr); end
    endtask

    task automatic test_single_push();
        do_reset();
        in_valid = 1'b1;
        in_pc    = 32'h100;
        in_instr = 32'h0000_0013;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%0b exp=0", out_valid); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%0b exp=1", out_valid); end
        checks++; if (out_pc !== 32'h100) begin failures++; $display("FAIL single_out_pc got=%0h exp=100", out_pc); end
        checks++; if (out_instr !== 32'h0000_0013) begin failures++; $display("FAIL single_out_instr got=%0h exp=13", out_instr); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_pop_count got=%0d exp=0", count); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 4; i++) push_one(32'(i * 4));
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%0b exp=0", in_ready); end
        push_one(32'h10);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_reject_count got=%0d exp=4", count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_pc !== 32'(i * 4)) begin failures++; $display("FAIL drain_pc[%0d] got=%0h exp=%0h", i, out_pc, i * 4); end
            checks++; if (out_instr !== instr_of(32'(i * 4))) begin failures++; $display("FAIL drain_instr[%0d] got=%0h exp=%0h", i, out_instr, instr_of(32'(i * 4))); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_out_valid got=%0b exp=0", out_valid); end
    endtask

    task automatic test_empty_pop();
        do_reset();
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", count); end
        push_one(32'h500);
        checks++; if (out_pc !== 32'h500) begin failures++; $display("FAIL empty_pop_then_push got=%0h exp=500", out_pc); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL empty_pop_then_count got=%0d exp=1", count); end
    endtask

    task automatic test_full_pop_wrap();
        do_reset();
        for (int i = 0; i < 4; i++) push_one(32'h40 + 32'(i * 4));
        in_valid  = 1'b1;
        in_pc     = 32'h50;
        in_instr  = instr_of(32'h50);
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_pop_in_ready got=%0b exp=0", in_ready); end
        tick();
        out_ready = 1'b0;
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL full_pop_count got=%0d exp=3", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_pop_freed got=%0b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL wrap_push_count got=%0d exp=4", count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_pc !== 32'h44 + 32'(i * 4)) begin failures++; $display("FAIL wrap_drain_pc[%0d] got=%0h exp=%0h", i, out_pc, 32'h44 + i * 4); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_one(32'h1000);
        push_one(32'h1004);
        for (int k = 0; k < 10; k++) begin
            in_valid  = 1'b1;
            in_pc     = 32'h1008 + 32'(k * 4);
            in_instr  = instr_of(in_pc);
            out_ready = 1'b1;
            #1;
            checks++; if (out_pc !== 32'h1000 + 32'(k * 4)) begin failures++; $display("FAIL b2b_pc[%0d] got=%0h exp=%0h", k, out_pc, 32'h1000 + k * 4); end
            tick();
            checks++; if (count !== 3'd2) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=2", k, count); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (out_pc !== 32'h1028) begin failures++; $display("FAIL b2b_tail0 got=%0h exp=1028", out_pc); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_pc !== 32'h102C) begin failures++; $display("FAIL b2b_tail1 got=%0h exp=102c", out_pc); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) push_one(32'h20 + 32'(i * 4));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 32'h200;
        in_instr = instr_of(32'h200);
        #1;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_cycle_flags got=%0b%0b exp=11", out_valid, in_ready); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        push_one(32'h208);
        checks++; if (out_pc !== 32'h208) begin failures++; $display("FAIL flush_next_pc got=%0h exp=208", out_pc); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL flush_next_count got=%0d exp=1", count); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 3; i++) push_one(32'h60 + 32'(i * 4));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL mid_reset_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL mid_reset_out_pc got=%0h exp=0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL mid_reset_out_instr got=%0h exp=0", out_instr); end
        push_one(32'h300);
        checks++; if (out_pc !== 32'h300) begin failures++; $display("FAIL mid_reset_first_pc got=%0h exp=300", out_pc); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_push();
        test_fill_drain();
        test_empty_pop();
        test_full_pop_wrap();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifu_ibuf.md
IFU_IBUF -- requirements
Module: ifu_ibuf

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of buffer entries (power of two, >= 2).
REQ-002 SHALL provide parameter DW, default 32, instruction width in bits.
REQ-003 SHALL provide parameter AW, default 32, PC width in bits.
REQ-004 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL provide port flush  input  1  discard all buffered entries (branch/exception redirect).
REQ-007 SHALL provide port in_valid  input  1  fetch stage presents an instruction.
REQ-008 SHALL provide port in_ready  output  1  buffer can accept an instruction this cycle.
REQ-009 SHALL provide port in_pc  input  AW  PC of the presented instruction.
REQ-010 SHALL provide port in_instr  input  DW  presented instruction word.
REQ-011 SHALL provide port out_valid  output  1  head entry valid for decode.
REQ-012 SHALL provide port out_ready  input  1  decode consumes the head entry this cycle.
REQ-013 SHALL provide port out_pc  output  AW  PC of the head entry.
REQ-014 SHALL provide port out_instr  output  DW  instruction word of the head entry.
REQ-015 SHALL provide port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 SHALL operate as an in-order FIFO: push when in_valid && in_ready; pop when out_valid && out_ready.
REQ-017 SHALL drive in_ready = (count != DEPTH), with no combinational dependence on out_ready or in_valid.
REQ-018 SHALL drive out_valid = (count != 0), and out_pc/out_instr from the entry at the read pointer.
REQ-019 SHALL impose 1-cycle latency: an entry pushed at edge N is visible on out_* from edge N onward (out_valid high in cycle N+1), never in the push cycle itself.
REQ-020 SHALL advance the write and read pointers modulo DEPTH, wrapping from DEPTH-1 to 0.
REQ-021 SHALL, on simultaneous push and pop, write the new entry, retire the head, and leave count unchanged.
REQ-022 SHALL, when full, refuse input (in_ready=0) even if out_ready=1 in the same cycle; the freed slot is usable next cycle.
REQ-023 SHALL, when empty, ignore out_ready and leave state unchanged.
REQ-024 SHALL give flush priority over push and pop: at the edge where flush=1, count, write pointer and read pointer become 0, and any in_valid data in that cycle is dropped.
REQ-025 SHALL drive in_ready and out_valid combinationally from current count, including during a flush cycle (flush takes effect at the clock edge).
REQ-026 SHALL keep count equal to the number of accepted-minus-retired entries, never exceeding DEPTH or going below 0.
REQ-027 SHALL not modify stored entry contents except on push to that entry.

Reset
REQ-028 SHALL, at a rising clk edge with rst_n=0, clear count, both pointers, and all entry storage to 0.
REQ-029 SHALL, after reset, present out_valid=0, in_ready=1, count=0, out_pc=0, out_instr=0.
REQ-030 SHALL give reset priority over flush, push and pop; reset asserted mid-stream discards all entries.

Verification
REQ-031 Bench SHALL cover: reset, then push (pc=0x100, instr=0x00000013) -> cycle after push out_valid=1, out_pc=0x100, out_instr=0x00000013, count=1.
REQ-032 Bench SHALL cover: 4 pushes pc=0x0/0x4/0x8/0xC with out_ready=0 -> count=4, in_ready=0; 5th push with pc=0x10 rejected; then 4 pops return 0x0,0x4,0x8,0xC in order, count=0.
REQ-033 Bench SHALL cover: full buffer, in_valid=1 and out_ready=1 same cycle -> pop only, count 4->3; next cycle push accepted, count=4, wrap of write pointer to entry 0.
REQ-034 Bench SHALL cover: count=2, push and pop same cycle for 10 cycles with pc stepping by 4 -> count stays 2, out_pc sequence strictly increasing by 4 with no gaps or duplicates.
REQ-035 Bench SHALL cover: count=3, flush=1 with in_valid=1 (pc=0x200) -> next cycle count=0, out_valid=0, in_ready=1; pc=0x200 never appears on out_pc.
REQ-036 Bench SHALL cover: count=3, rst_n=0 for one edge -> count=0, out_valid=0, out_pc=0, out_instr=0; subsequent push pc=0x300 emerges first.
